// File: rtl/fast_square_framer.sv
// fast_square_framer
// Frames decimated I/Q samples from each frequency-step record window with a
// header {SYNC_WORD, {step_index, sweep_count}} and a trailer
// {~SYNC_WORD, sample_count}, buffered through a small FIFO for rx_buffer.
//
// Ports:
//   clock, reset_n          master clock, async active-low reset
//   enable                  framer enable; low flushes FIFO and window state
//   step_reset, step        sweep / frequency-step pulses
//   record                  record window level
//   in_strobe, i_in, q_in   input sample and valid
//   out_strobe              consumer pop strobe
//   clear_status            clears the sticky overflow flag
//   i_out, q_out, out_valid registered output pair and pop-valid flag
//   overflow                sticky drop flag
//   step_index, sweep_count current step and wrapping sweep count
module fast_square_framer #(
    parameter logic [15:0] SYNC_WORD       = 16'hA5C3,
    parameter int unsigned NUM_FREQ_STEPS  = 32,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        step_reset,
    input  logic        step,
    input  logic        record,
    input  logic        in_strobe,
    input  logic [15:0] i_in,
    input  logic [15:0] q_in,
    input  logic        out_strobe,
    input  logic        clear_status,
    output logic [15:0] i_out,
    output logic [15:0] q_out,
    output logic        out_valid,
    output logic        overflow,
    output logic [7:0]  step_index,
    output logic [7:0]  sweep_count
);

    localparam int unsigned AW        = FIFO_DEPTH_LOG2;
    localparam int unsigned DEPTH     = 1 << AW;
    localparam logic [7:0]  LAST_STEP = 8'(NUM_FREQ_STEPS - 1);

    logic [31:0] r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        r_record_q;
    logic [15:0] r_samp_cnt;
    logic [15:0] r_i_out;
    logic [15:0] r_q_out;
    logic        r_out_valid;
    logic        r_overflow;
    logic [7:0]  r_step_index;
    logic [7:0]  r_sweep_count;

    logic        w_full;
    logic        w_empty;
    logic        w_rise;
    logic        w_samp;
    logic        w_fall;
    logic        w_push_req;
    logic        w_push;
    logic        w_pop;
    logic        w_drop;
    logic [31:0] w_push_word;
    logic [31:0] w_rd_word;

    // FIFO status: the extra pointer bit separates full from empty.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    // Window events; edge cycles never carry samples, so at most one push.
    assign w_rise = enable &  record & ~r_record_q;
    assign w_samp = enable &  record &  r_record_q & in_strobe;
    assign w_fall = enable & ~record &  r_record_q;

    assign w_push_req = w_rise | w_samp | w_fall;
    assign w_pop      = enable & out_strobe & ~w_empty;
    // A full FIFO still accepts a word when a pop frees a slot this cycle.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & ~w_push;

    // Select the word to push for the current window event.
    always_comb begin
        w_push_word = {i_in, q_in};
        if (w_rise) begin
            w_push_word = {SYNC_WORD, r_step_index, r_sweep_count};
        end else if (w_fall) begin
            w_push_word = {~SYNC_WORD, r_samp_cnt};
        end
    end

    assign w_rd_word = r_mem[r_rptr[AW-1:0]];

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_push_word;
        end
    end

    // Step and sweep counters track regardless of enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_step_index  <= '0;
            r_sweep_count <= '0;
        end else if (step_reset) begin
            r_step_index  <= '0;
            r_sweep_count <= r_sweep_count + 8'd1;
        end else if (step) begin
            if (r_step_index == LAST_STEP) begin
                r_step_index  <= '0;
                r_sweep_count <= r_sweep_count + 8'd1;
            end else begin
                r_step_index  <= r_step_index + 8'd1;
            end
        end
    end

    // Framing, FIFO pointers and output register; enable low flushes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_record_q  <= 1'b0;
            r_samp_cnt  <= '0;
            r_i_out     <= '0;
            r_q_out     <= '0;
            r_out_valid <= 1'b0;
        end else if (!enable) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_record_q  <= 1'b0;
            r_samp_cnt  <= '0;
            r_out_valid <= 1'b0;
            if (out_strobe) begin
                r_i_out <= '0;
                r_q_out <= '0;
            end
        end else begin
            r_record_q <= record;
            if (w_push) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (out_strobe) begin
                if (w_pop) begin
                    r_rptr      <= r_rptr + (AW+1)'(1);
                    r_i_out     <= w_rd_word[31:16];
                    r_q_out     <= w_rd_word[15:0];
                    r_out_valid <= 1'b1;
                end else begin
                    r_i_out     <= '0;
                    r_q_out     <= '0;
                    r_out_valid <= 1'b0;
                end
            end
            // Only samples actually written are counted; saturates at 16'hFFFF.
            if (w_rise) begin
                r_samp_cnt <= '0;
            end else if (w_samp && w_push && (r_samp_cnt != 16'hFFFF)) begin
                r_samp_cnt <= r_samp_cnt + 16'd1;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle beats clear_status.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_status) begin
            r_overflow <= 1'b0;
        end
    end

    assign i_out       = r_i_out;
    assign q_out       = r_q_out;
    assign out_valid   = r_out_valid;
    assign overflow    = r_overflow;
    assign step_index  = r_step_index;
    assign sweep_count = r_sweep_count;

endmodule

// File: tb/tb_fast_square_framer.sv
// Self-checking bench for fast_square_framer: expected words are queued when
// stimulus should produce a push and compared when the bench pops them.
module tb_fast_square_framer;

    localparam int unsigned DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        step_reset = 1'b0;
    logic        step = 1'b0;
    logic        record = 1'b0;
    logic        in_strobe = 1'b0;
    logic [15:0] i_in = '0;
    logic [15:0] q_in = '0;
    logic        out_strobe = 1'b0;
    logic        clear_status = 1'b0;
    logic [15:0] i_out;
    logic [15:0] q_out;
    logic        out_valid;
    logic        overflow;
    logic [7:0]  step_index;
    logic [7:0]  sweep_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb [$];

    fast_square_framer #(
        .SYNC_WORD      (16'hA5C3),
        .NUM_FREQ_STEPS (32),
        .FIFO_DEPTH_LOG2(4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .step_reset  (step_reset),
        .step        (step),
        .record      (record),
        .in_strobe   (in_strobe),
        .i_in        (i_in),
        .q_in        (q_in),
        .out_strobe  (out_strobe),
        .clear_status(clear_status),
        .i_out       (i_out),
        .q_out       (q_out),
        .out_valid   (out_valid),
        .overflow    (overflow),
        .step_index  (step_index),
        .sweep_count (sweep_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // One clock with the current inputs; scoreboard pop on out_strobe, then
    // queue the word this cycle is expected to push.
    task automatic run_cycle(input bit push_exp, input logic [31:0] word);
        bit          strobe_now;
        bit          exp_v;
        logic [31:0] exp_w;
        strobe_now = out_strobe;
        tick();
        if (strobe_now) begin
            exp_v = 1'b0;
            exp_w = '0;
            if (sb.size() > 0) begin
                exp_v = 1'b1;
                exp_w = sb.pop_front();
            end
            n_tests++;
            if (out_valid !== exp_v || {i_out, q_out} !== exp_w) begin
                n_fail++;
                $display("FAIL pop: got valid=%0b word=%h, expected valid=%0b word=%h",
                         out_valid, {i_out, q_out}, exp_v, exp_w);
            end
        end
        if (push_exp) sb.push_back(word);
    endtask

    task automatic apply_reset;
        reset_n = 1'b0; enable = 1'b1; step_reset = 1'b0; step = 1'b0;
        record = 1'b0; in_strobe = 1'b0; i_in = '0; q_in = '0;
        out_strobe = 1'b0; clear_status = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick(); tick();
        n_tests++;
        if ({i_out, q_out, out_valid, overflow, step_index, sweep_count} !== 50'd0) begin
            n_fail++;
            $display("FAIL reset_values: got i=%h q=%h v=%0b ovf=%0b step=%0d sweep=%0d, expected all 0",
                     i_out, q_out, out_valid, overflow, step_index, sweep_count);
        end
        apply_reset();
    endtask

    task automatic test_basic_window;
        for (int c = 0; c < 28; c++) begin
            record     = (c < 5);
            in_strobe  = 1'b1;
            i_in       = 16'(c);
            q_in       = 16'(c);
            out_strobe = ((c % 4) == 3);
            if (c == 0)      run_cycle(1'b1, 32'hA5C3_0000);
            else if (c < 5)  run_cycle(1'b1, {16'(c), 16'(c)});
            else if (c == 5) run_cycle(1'b1, 32'h5A3C_0004);
            else             run_cycle(1'b0, '0);
        end
        in_strobe = 1'b0; out_strobe = 1'b0;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL basic_drain: got %0d words left, expected 0", sb.size());
        end
    endtask

    task automatic pulse_window(input logic [15:0] hdr_q);
        record = 1'b1;
        run_cycle(1'b1, {16'hA5C3, hdr_q});
        record = 1'b0;
        run_cycle(1'b1, 32'h5A3C_0000);
        run_cycle(1'b0, '0);
    endtask

    task automatic test_counters;
        apply_reset();
        out_strobe = 1'b1;
        pulse_window(16'h0000);
        for (int s = 1; s <= 3; s++) begin
            step = 1'b1; run_cycle(1'b0, '0); step = 1'b0;
            pulse_window({8'(s), 8'h00});
        end
        step_reset = 1'b1; run_cycle(1'b0, '0); step_reset = 1'b0;
        n_tests++;
        if (step_index !== 8'd0 || sweep_count !== 8'd1) begin
            n_fail++;
            $display("FAIL step_reset: got step=%0d sweep=%0d, expected 0/1", step_index, sweep_count);
        end
        pulse_window(16'h0001);
        run_cycle(1'b0, '0);
        out_strobe = 1'b0;
    endtask

    task automatic test_step_wrap;
        apply_reset();
        for (int s = 0; s < 31; s++) begin
            step = 1'b1; tick();
        end
        step = 1'b0;
        n_tests++;
        if (step_index !== 8'd31 || sweep_count !== 8'd0) begin
            n_fail++;
            $display("FAIL step_31: got step=%0d sweep=%0d, expected 31/0", step_index, sweep_count);
        end
        step = 1'b1; tick(); step = 1'b0;
        n_tests++;
        if (step_index !== 8'd0 || sweep_count !== 8'd1) begin
            n_fail++;
            $display("FAIL step_wrap: got step=%0d sweep=%0d, expected 0/1", step_index, sweep_count);
        end
        step = 1'b1; tick();
        step_reset = 1'b1; tick();
        step = 1'b0; step_reset = 1'b0;
        n_tests++;
        if (step_index !== 8'd0 || sweep_count !== 8'd2) begin
            n_fail++;
            $display("FAIL step_reset_wins: got step=%0d sweep=%0d, expected 0/2", step_index, sweep_count);
        end
    endtask

    task automatic test_overflow;
        bit ok;
        apply_reset();
        out_strobe = 1'b0;
        record = 1'b1;
        run_cycle(1'b1, 32'hA5C3_0000);
        in_strobe = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            i_in = 16'(16'h0100 + c);
            q_in = 16'(c);
            clear_status = (c == 20);
            ok = (sb.size() < DEPTH);
            run_cycle(ok, {i_in, q_in});
        end
        clear_status = 1'b0;
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_beats_clear: got overflow=%0b, expected 1", overflow);
        end
        in_strobe = 1'b0; record = 1'b0;
        run_cycle(1'b0, '0);
        clear_status = 1'b1;
        run_cycle(1'b0, '0);
        clear_status = 1'b0;
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_status: got overflow=%0b, expected 0", overflow);
        end
        record = 1'b1; out_strobe = 1'b1;
        run_cycle(1'b1, 32'hA5C3_0000);
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_with_pop: got overflow=%0b, expected 0", overflow);
        end
        for (int c = 0; c < 17; c++) run_cycle(1'b0, '0);
        record = 1'b0;
        run_cycle(1'b1, 32'h5A3C_0000);
        for (int c = 0; c < 3; c++) run_cycle(1'b0, '0);
        out_strobe = 1'b0;
    endtask

    task automatic test_record_pulse;
        apply_reset();
        out_strobe = 1'b1;
        pulse_window(16'h0000);
        out_strobe = 1'b0;
    endtask

    task automatic test_flush;
        apply_reset();
        record = 1'b1; in_strobe = 1'b1; i_in = 16'h1111; q_in = 16'h2222;
        run_cycle(1'b1, 32'hA5C3_0000);
        run_cycle(1'b1, 32'h1111_2222);
        run_cycle(1'b1, 32'h1111_2222);
        in_strobe = 1'b0;
        enable = 1'b0; step = 1'b1;
        run_cycle(1'b0, '0);
        sb.delete();
        enable = 1'b1; step = 1'b0; out_strobe = 1'b1;
        run_cycle(1'b1, 32'hA5C3_0100);
        record = 1'b0;
        run_cycle(1'b1, 32'h5A3C_0000);
        run_cycle(1'b0, '0);
        run_cycle(1'b0, '0);
        out_strobe = 1'b0;
    endtask

    task automatic test_reset_mid_window;
        apply_reset();
        step_reset = 1'b1; tick(); step_reset = 1'b0;
        record = 1'b1; in_strobe = 1'b1; i_in = 16'h3333; q_in = 16'h4444;
        run_cycle(1'b1, 32'hA5C3_0001);
        run_cycle(1'b1, 32'h3333_4444);
        out_strobe = 1'b1;
        run_cycle(1'b1, 32'h3333_4444);
        out_strobe = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({i_out, q_out, out_valid, step_index, sweep_count} !== 49'd0) begin
            n_fail++;
            $display("FAIL async_reset: got i=%h q=%h v=%0b step=%0d sweep=%0d, expected all 0",
                     i_out, q_out, out_valid, step_index, sweep_count);
        end
        tick();
        reset_n = 1'b1;
        sb.delete();
        in_strobe = 1'b0; out_strobe = 1'b1;
        run_cycle(1'b1, 32'hA5C3_0000);
        record = 1'b0;
        run_cycle(1'b1, 32'h5A3C_0000);
        run_cycle(1'b0, '0);
        run_cycle(1'b0, '0);
        out_strobe = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_counters();
        test_step_wrap();
        test_overflow();
        test_record_pulse();
        test_flush();
        test_reset_mid_window();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
